fifo_burst_reader: RTL and testbench

Read-domain consumer for the dual-clock FIFO. It drains the FIFO's read port (`read`, 1-cycle-latency `dout`, `data_cnt`, `empty`) into a valid/ready output stream. Words are grouped into bursts: a burst starts when a full burst is buffered or when an idle timeout expires with data pending. The last word of each burst is flagged. It sits on the FIFO's read clock, between the FIFO and a downstream packet consumer such as a DMA or serializer.

---
 rtl/fifo_burst_reader.sv | 135 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Drains the dual-clock FIFO read port into a valid/ready stream, grouped into BURST-word or timed-out partial bursts.
// fifo_read to m_valid is 2 cycles; with m_ready low, reads stop once 3 words are buffered or in flight.
module fifo_burst_reader #(
    parameter int DW      = 8,
    parameter int AW      = 10,
    parameter int BURST   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          r_clk,
    input  logic          r_rst_n,
    output logic          fifo_read,
    input  logic [DW-1:0] fifo_dout,
    input  logic [AW-1:0] fifo_data_cnt,
    input  logic          fifo_empty,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_L = TW'(TIMEOUT);
    localparam logic [AW-1:0] BURST_L   = AW'(BURST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DRAIN
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [AW-1:0] len;
    logic [AW-1:0] issued;
    logic          inflight;
    logic          inflight_last;
    logic [DW-1:0] buf_dat [0:2];
    logic [2:0]    buf_last;
    logic [1:0]    wr_ptr;
    logic [1:0]    rd_ptr;
    logic [1:0]    occ;
    logic          xfer;
    logic          last_issue;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign m_valid    = (occ != 2'd0);
    assign m_data     = buf_dat[rd_ptr];
    assign m_last     = buf_last[rd_ptr];
    assign busy       = (state != S_IDLE);
    assign xfer       = m_valid && m_ready;
    assign last_issue = (issued == len - AW'(1));

    // Only registered terms besides fifo_empty: m_ready never reaches fifo_read combinationally.
    assign fifo_read = (state == S_BURST) && !fifo_empty && (issued < len)
                     && ((3'(occ) + 3'(inflight)) < 3'd3);

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            state  <= S_IDLE;
            timer  <= '0;
            len    <= '0;
            issued <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fifo_data_cnt >= BURST_L) begin
                        state  <= S_BURST;
                        len    <= BURST_L;
                        timer  <= '0;
                        issued <= '0;
                    end else if (timer == TIMEOUT_L && !fifo_empty) begin
                        state  <= S_BURST;
                        len    <= fifo_data_cnt;
                        timer  <= '0;
                        issued <= '0;
                    end else if (fifo_empty) begin
                        timer <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_BURST: begin
                    if (fifo_read) begin
                        issued <= issued + AW'(1);
                        if (last_issue) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (xfer && m_last) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Three-entry skid buffer absorbing the 1-cycle FIFO read latency plus one stalled word.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= 2'd0;
            rd_ptr        <= 2'd0;
            occ           <= 2'd0;
            buf_last      <= 3'd0;
            for (int i = 0; i < 3; i++) begin
                buf_dat[i] <= '0;
            end
        end else begin
            inflight      <= fifo_read;
            inflight_last <= fifo_read && last_issue;
            if (inflight) begin
                buf_dat[wr_ptr]  <= fifo_dout;
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= next_ptr(wr_ptr);
            end
            if (xfer) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({inflight, xfer})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: behavioural FIFO read port, stream monitor, per-scenario tasks.
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int AW = 10;

    logic          r_clk = 1'b0;
    logic          r_rst_n;
    logic          fifo_read;
    logic [DW-1:0] fifo_dout = '0;
    logic [AW-1:0] fifo_data_cnt;
    logic          fifo_empty;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_burst_reader #(.DW(DW), .AW(AW), .BURST(16), .TIMEOUT(255)) dut (
        .r_clk(r_clk), .r_rst_n(r_rst_n), .fifo_read(fifo_read), .fifo_dout(fifo_dout),
        .fifo_data_cnt(fifo_data_cnt), .fifo_empty(fifo_empty), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy)
    );

    always #5 r_clk = ~r_clk;

    // Behavioural FIFO read side: data one cycle after fifo_read, count updated at the edge.
    logic [DW-1:0] fmem [0:1023];
    int   wr_idx = 0;
    int   rd_idx = 0;
    logic rd_when_empty = 1'b0;

    assign fifo_data_cnt = AW'(wr_idx - rd_idx);
    assign fifo_empty    = (wr_idx == rd_idx);

    always @(posedge r_clk) begin
        if (fifo_read) begin
            if (wr_idx == rd_idx) begin
                rd_when_empty <= 1'b1;
            end else begin
                fifo_dout <= fmem[rd_idx % 1024];
                rd_idx    <= rd_idx + 1;
            end
        end
    end

    logic [DW-1:0] rx_data [0:511];
    logic          rx_last [0:511];
    int            rx_n = 0;

    always @(negedge r_clk) begin
        if (r_rst_n && m_valid && m_ready) begin
            rx_data[rx_n] <= m_data;
            rx_last[rx_n] <= m_last;
            rx_n          <= rx_n + 1;
        end
    end

    task automatic clk1;
        @(posedge r_clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        fmem[wr_idx % 1024] = v;
        wr_idx = wr_idx + 1;
    endtask

    task automatic do_reset;
        r_rst_n = 1'b0;
        m_ready = 1'b0;
        #1;
        wr_idx = rd_idx;
        clk1;
        clk1;
        r_rst_n = 1'b1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 40; i++) push(DW'(i));
        r_rst_n = 1'b1;
        m_ready = 1'b1;
        #2;
        r_rst_n = 1'b0;
        #2;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b, expected 0", m_valid); end
        clk1; clk1; clk1;
        @(negedge r_clk);
        n_checks++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_read: got %b, expected 0", fifo_read); end
        n_checks++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b, expected 0", m_last); end
        n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h, expected 00", m_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_held: got %b, expected 0", busy); end
        clk1;
    endtask

    task automatic test_two_bursts;
        logic rd_t [0:40];
        logic bz_t [0:40];
        logic mv_t [0:40];
        int   base;
        int   nrd;
        do_reset;
        m_ready = 1'b1;
        base = rx_n;
        for (int i = 0; i < 40; i++) push(DW'(i));
        for (int c = 0; c <= 40; c++) begin
            @(negedge r_clk);
            rd_t[c] = fifo_read; bz_t[c] = busy; mv_t[c] = m_valid;
            clk1;
        end
        nrd = 0;
        for (int c = 1; c <= 16; c++) if (rd_t[c]) nrd++;
        n_checks++; if (bz_t[0] !== 1'b0) begin n_fail++; $display("FAIL tb_busy_c0: got %b, expected 0", bz_t[0]); end
        n_checks++; if (bz_t[1] !== 1'b1) begin n_fail++; $display("FAIL tb_busy_c1: got %b, expected 1", bz_t[1]); end
        n_checks++; if (nrd != 16) begin n_fail++; $display("FAIL tb_consecutive_reads: got %0d, expected 16", nrd); end
        n_checks++; if (rd_t[17] !== 1'b0) begin n_fail++; $display("FAIL tb_read_c17: got %b, expected 0", rd_t[17]); end
        n_checks++; if (mv_t[2] !== 1'b0) begin n_fail++; $display("FAIL tb_valid_c2: got %b, expected 0", mv_t[2]); end
        n_checks++; if (mv_t[3] !== 1'b1) begin n_fail++; $display("FAIL tb_valid_c3: got %b, expected 1", mv_t[3]); end
        n_checks++; if (bz_t[19] !== 1'b0) begin n_fail++; $display("FAIL tb_busy_c19: got %b, expected 0", bz_t[19]); end
        n_checks++; if (bz_t[20] !== 1'b1 || rd_t[20] !== 1'b1) begin n_fail++; $display("FAIL tb_second_start: got busy %b read %b, expected 1 1", bz_t[20], rd_t[20]); end
        n_checks++; if (rx_n - base != 32) begin n_fail++; $display("FAIL tb_count: got %0d, expected 32", rx_n - base); end
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (rx_data[base+k] !== DW'(k) || rx_last[base+k] !== (k == 15 || k == 31)) begin
                n_fail++;
                $display("FAIL tb_word%0d: got %h last %b, expected %h last %b", k, rx_data[base+k], rx_last[base+k], DW'(k), (k == 15 || k == 31));
            end
        end
    endtask

    task automatic test_timeout;
        int   base;
        int   reads;
        logic bz255;
        logic bz262;
        logic bz263;
        do_reset;
        m_ready = 1'b1;
        base = rx_n;
        reads = 0;
        for (int i = 0; i < 5; i++) push(DW'(32'hA0 + i));
        for (int c = 0; c <= 263; c++) begin
            @(negedge r_clk);
            if (c <= 255 && fifo_read) reads++;
            if (c == 255) bz255 = busy;
            if (c == 256) begin
                n_checks++; if (fifo_read !== 1'b1) begin n_fail++; $display("FAIL to_first_read: got %b, expected 1", fifo_read); end
            end
            if (c == 262) bz262 = busy;
            if (c == 263) bz263 = busy;
            clk1;
        end
        n_checks++; if (reads != 0) begin n_fail++; $display("FAIL to_early_reads: got %0d, expected 0", reads); end
        n_checks++; if (bz255 !== 1'b0) begin n_fail++; $display("FAIL to_busy255: got %b, expected 0", bz255); end
        n_checks++; if (bz262 !== 1'b1 || bz263 !== 1'b0) begin n_fail++; $display("FAIL to_busy_end: got %b%b, expected 10", bz262, bz263); end
        n_checks++; if (rx_n - base != 5) begin n_fail++; $display("FAIL to_count: got %0d, expected 5", rx_n - base); end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (rx_data[base+k] !== DW'(32'hA0 + k) || rx_last[base+k] !== (k == 4)) begin
                n_fail++;
                $display("FAIL to_word%0d: got %h last %b, expected %h last %b", k, rx_data[base+k], rx_last[base+k], DW'(32'hA0 + k), (k == 4));
            end
        end
        base = rx_n;
        reads = 0;
        for (int i = 0; i < 3; i++) push(DW'(32'hB0 + i));
        for (int c = 0; c <= 262; c++) begin
            @(negedge r_clk);
            if (c <= 255 && fifo_read) reads++;
            if (c == 256) begin
                n_checks++; if (fifo_read !== 1'b1) begin n_fail++; $display("FAIL to2_first_read: got %b, expected 1", fifo_read); end
            end
            if (c == 261) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to2_busy_end: got %b, expected 0", busy); end
            end
            clk1;
        end
        n_checks++; if (reads != 0) begin n_fail++; $display("FAIL to2_early_reads: got %0d, expected 0", reads); end
        n_checks++; if (rx_n - base != 3) begin n_fail++; $display("FAIL to2_count: got %0d, expected 3", rx_n - base); end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (rx_data[base+k] !== DW'(32'hB0 + k) || rx_last[base+k] !== (k == 2)) begin
                n_fail++;
                $display("FAIL to2_word%0d: got %h last %b, expected %h last %b", k, rx_data[base+k], rx_last[base+k], DW'(32'hB0 + k), (k == 2));
            end
        end
    endtask

    task automatic test_toggle_ready;
        int            base;
        int            reads;
        int            xfers;
        int            viol_full;
        int            viol_hold;
        logic          prev_stall;
        logic [DW-1:0] prev_d;
        logic          prev_l;
        do_reset;
        base = rx_n;
        reads = 0; xfers = 0; viol_full = 0; viol_hold = 0; prev_stall = 1'b0;
        prev_d = '0; prev_l = 1'b0;
        for (int i = 0; i < 16; i++) push(DW'(32'h40 + i));
        for (int c = 0; c < 100; c++) begin
            m_ready = (c % 2 == 0);
            @(negedge r_clk);
            if (fifo_read && (reads - xfers) >= 3) viol_full++;
            if (prev_stall && (!m_valid || m_data !== prev_d || m_last !== prev_l)) viol_hold++;
            prev_stall = m_valid && !m_ready;
            prev_d = m_data;
            prev_l = m_last;
            if (fifo_read) reads++;
            if (m_valid && m_ready) xfers++;
            clk1;
        end
        n_checks++; if (viol_full != 0) begin n_fail++; $display("FAIL tog_read_when_full: got %0d, expected 0", viol_full); end
        n_checks++; if (viol_hold != 0) begin n_fail++; $display("FAIL tog_stall_stable: got %0d, expected 0", viol_hold); end
        n_checks++; if (reads != 16) begin n_fail++; $display("FAIL tog_reads: got %0d, expected 16", reads); end
        n_checks++; if (rx_n - base != 16) begin n_fail++; $display("FAIL tog_count: got %0d, expected 16", rx_n - base); end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (rx_data[base+k] !== DW'(32'h40 + k) || rx_last[base+k] !== (k == 15)) begin
                n_fail++;
                $display("FAIL tog_word%0d: got %h last %b, expected %h last %b", k, rx_data[base+k], rx_last[base+k], DW'(32'h40 + k), (k == 15));
            end
        end
    endtask

    task automatic test_stall;
        int   base;
        int   reads;
        int   xfers;
        int   stall_reads;
        int   rel_x;
        int   diff26;
        logic mv26;
        do_reset;
        m_ready = 1'b1;
        base = rx_n;
        reads = 0; xfers = 0; stall_reads = 0; rel_x = 0; diff26 = 0; mv26 = 1'b0;
        for (int i = 0; i < 16; i++) push(DW'(32'h50 + i));
        for (int c = 0; c <= 60; c++) begin
            if (c == 7) m_ready = 1'b0;
            if (c == 27) m_ready = 1'b1;
            @(negedge r_clk);
            if (c >= 8 && c <= 26 && fifo_read) stall_reads++;
            if (c == 26) begin
                diff26 = reads - xfers;
                mv26 = m_valid;
            end
            if (c >= 27 && c <= 38 && m_valid && m_ready) rel_x++;
            if (fifo_read) reads++;
            if (m_valid && m_ready) xfers++;
            clk1;
        end
        n_checks++; if (stall_reads != 0) begin n_fail++; $display("FAIL st_reads_in_stall: got %0d, expected 0", stall_reads); end
        n_checks++; if (diff26 != 3) begin n_fail++; $display("FAIL st_words_ahead: got %0d, expected 3", diff26); end
        n_checks++; if (mv26 !== 1'b1) begin n_fail++; $display("FAIL st_valid_held: got %b, expected 1", mv26); end
        n_checks++; if (rel_x != 12) begin n_fail++; $display("FAIL st_full_rate: got %0d, expected 12", rel_x); end
        n_checks++; if (rx_n - base != 16) begin n_fail++; $display("FAIL st_count: got %0d, expected 16", rx_n - base); end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (rx_data[base+k] !== DW'(32'h50 + k) || rx_last[base+k] !== (k == 15)) begin
                n_fail++;
                $display("FAIL st_word%0d: got %h last %b, expected %h last %b", k, rx_data[base+k], rx_last[base+k], DW'(32'h50 + k), (k == 15));
            end
        end
    endtask

    task automatic test_reset_mid_burst;
        int base;
        int reads;
        do_reset;
        for (int i = 0; i < 16; i++) push(DW'(32'h80 + i));
        for (int c = 0; c < 4; c++) begin
            @(negedge r_clk);
            clk1;
        end
        @(negedge r_clk);
        n_checks++; if (m_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rm_pre_state: got valid %b busy %b, expected 1 1", m_valid, busy); end
        r_rst_n = 1'b0;
        #1;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid_async: got %b, expected 0", m_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy_async: got %b, expected 0", busy); end
        n_checks++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL rm_read_async: got %b, expected 0", fifo_read); end
        clk1;
        clk1;
        r_rst_n = 1'b1;
        m_ready = 1'b1;
        base = rx_n;
        reads = 0;
        for (int c = 0; c <= 275; c++) begin
            @(negedge r_clk);
            if (c <= 255 && (fifo_read || busy)) reads++;
            if (c == 256) begin
                n_checks++; if (fifo_read !== 1'b1) begin n_fail++; $display("FAIL rm_resume_read: got %b, expected 1", fifo_read); end
            end
            clk1;
        end
        n_checks++; if (reads != 0) begin n_fail++; $display("FAIL rm_idle_after_reset: got %0d, expected 0", reads); end
        n_checks++; if (rx_n - base != 13) begin n_fail++; $display("FAIL rm_count: got %0d, expected 13", rx_n - base); end
        for (int k = 0; k < 13; k++) begin
            n_checks++;
            if (rx_data[base+k] !== DW'(32'h83 + k) || rx_last[base+k] !== (k == 12)) begin
                n_fail++;
                $display("FAIL rm_word%0d: got %h last %b, expected %h last %b", k, rx_data[base+k], rx_last[base+k], DW'(32'h83 + k), (k == 12));
            end
        end
    endtask

    task automatic test_burst_priority;
        int base;
        int reads;
        do_reset;
        m_ready = 1'b1;
        base = rx_n;
        reads = 0;
        for (int i = 0; i < 15; i++) push(DW'(32'hC0 + i));
        for (int c = 0; c <= 276; c++) begin
            if (c == 255) push(8'hCF);
            @(negedge r_clk);
            if (c <= 255 && fifo_read) reads++;
            if (c == 256) begin
                n_checks++; if (fifo_read !== 1'b1) begin n_fail++; $display("FAIL bp_first_read: got %b, expected 1", fifo_read); end
            end
            clk1;
        end
        n_checks++; if (reads != 0) begin n_fail++; $display("FAIL bp_early_reads: got %0d, expected 0", reads); end
        n_checks++; if (rx_n - base != 16) begin n_fail++; $display("FAIL bp_count: got %0d, expected 16", rx_n - base); end
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (rx_data[base+k] !== DW'(32'hC0 + k) || rx_last[base+k] !== (k == 15)) begin
                n_fail++;
                $display("FAIL bp_word%0d: got %h last %b, expected %h last %b", k, rx_data[base+k], rx_last[base+k], DW'(32'hC0 + k), (k == 15));
            end
        end
    endtask

    initial begin
        test_reset;
        test_two_bursts;
        test_timeout;
        test_toggle_ready;
        test_stall;
        test_reset_mid_burst;
        test_burst_priority;
        n_checks++;
        if (rd_when_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL read_while_empty: got %b, expected 0", rd_when_empty);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
